// File: rtl/quad_decoder_counter_pkg.sv
// Shared definitions for the quadrature decoder: mode encodings, FSM states
// and the forward (count-up) Gray sequence on {A,B}.
package quad_decoder_counter_pkg;

    typedef enum logic [1:0] {
        QD_X1  = 2'b00,
        QD_X2  = 2'b01,
        QD_X4  = 2'b10,
        QD_X4R = 2'b11
    } qd_mode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } qd_state_e;

    localparam int unsigned QD_SYNC_STAGES = 2;

    // Up sequence 00 -> 10 -> 11 -> 01 -> 00; down is the reverse.
    function automatic logic [1:0] qd_up_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_decoder_counter_if.sv
// Register-file side bus of the quadrature decoder: encoder pins, control
// strobes and the decoded position/status outputs.
interface quad_decoder_counter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             enc_a;
    logic             enc_b;
    logic             enc_i;
    logic [1:0]       mode;
    logic             index_clr_en;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             err_clr;
    logic [CNT_W-1:0] position;
    logic             dir;
    logic             step;
    logic             err_pulse;
    logic             err;
    logic             ready;

    modport master (
        output enc_a, enc_b, enc_i, mode, index_clr_en,
        output cnt_load, cnt_load_val, err_clr,
        input  position, dir, step, err_pulse, err, ready
    );

    modport slave (
        input  enc_a, enc_b, enc_i, mode, index_clr_en,
        input  cnt_load, cnt_load_val, err_clr,
        output position, dir, step, err_pulse, err, ready
    );
endinterface

// File: rtl/quad_decoder_counter_filter.sv
// Two-flop synchroniser followed by a stability filter: the output level only
// follows the synced input after FILTER_LEN consecutive differing samples.
module quad_input_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic filt_o,
    output logic filt_nxt_o
);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o     = filt_q;
    assign filt_nxt_o = filt_d;

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder: filtered A/B/I, x1/x2/x4 edge qualification, signed
// position counter with load / index clear and illegal-transition detection.
module quad_decoder_counter
    import quad_decoder_counter_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          SAT_EN     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_decoder_counter_if.slave  bus
);
    localparam int unsigned INIT_CYC = QD_SYNC_STAGES + FILTER_LEN;
    localparam int unsigned ICW      = $clog2(INIT_CYC + 1);
    localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic fa, fb, fi;
    logic fa_nxt, fb_nxt, fi_nxt;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .rst(rst), .pin_i(bus.enc_a), .filt_o(fa), .filt_nxt_o(fa_nxt)
    );
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .rst(rst), .pin_i(bus.enc_b), .filt_o(fb), .filt_nxt_o(fb_nxt)
    );
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
        .clk(clk), .rst(rst), .pin_i(bus.enc_i), .filt_o(fi), .filt_nxt_o(fi_nxt)
    );

    qd_state_e        state_q;
    logic [ICW-1:0]   init_cnt_q;
    logic [1:0]       prev_q;
    logic             i_prev_q;
    logic             ready_q;
    logic [CNT_W-1:0] pos_q;
    logic [CNT_W-1:0] pos_d;
    logic             dir_q;
    logic             step_q;
    logic             err_pulse_q;
    logic             err_q;

    logic [1:0] ab_cur;
    logic [1:0] ab_diff;
    logic       running;
    logic       valid_edge;
    logic       illegal;
    logic       step_up;
    logic       a_edge;
    logic       a_rise;
    logic       count_step;
    logic       idx_rise;

    assign ab_cur  = {fa, fb};
    assign ab_diff = prev_q ^ ab_cur;
    assign running = (state_q == ST_RUN);

    always_comb begin
        valid_edge = running && (ab_diff == 2'b01 || ab_diff == 2'b10);
        illegal    = running && (ab_diff == 2'b11);
        step_up    = (qd_up_next(prev_q) == ab_cur);
        a_edge     = ab_diff[1];
        a_rise     = ab_diff[1] & ab_cur[1];
        count_step = 1'b0;
        case (qd_mode_e'(bus.mode))
            // x1 counts one A transition per cycle in either direction.
            QD_X1:   count_step = valid_edge && a_edge && (step_up ? a_rise : !a_rise);
            QD_X2:   count_step = valid_edge && a_edge;
            default: count_step = valid_edge;
        endcase
        idx_rise = running && bus.index_clr_en && fi && !i_prev_q;
    end

    always_comb begin
        pos_d = pos_q;
        if (bus.cnt_load) begin
            pos_d = bus.cnt_load_val;
        end else if (idx_rise) begin
            pos_d = '0;
        end else if (count_step) begin
            if (step_up) begin
                pos_d = (SAT_EN && pos_q == POS_MAX) ? pos_q : pos_q + 1'b1;
            end else begin
                pos_d = (SAT_EN && pos_q == POS_MIN) ? pos_q : pos_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            prev_q      <= '0;
            i_prev_q    <= 1'b0;
            ready_q     <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            step_q      <= count_step;
            err_pulse_q <= illegal;
            err_q       <= illegal | (err_q & ~bus.err_clr);
            if (count_step) begin
                dir_q <= step_up;
            end
            case (state_q)
                ST_INIT: begin
                    // Prime from the filters' next levels so a level accepted on
                    // the last priming cycle is not seen as an edge in RUN.
                    prev_q   <= {fa_nxt, fb_nxt};
                    i_prev_q <= fi_nxt;
                    if (init_cnt_q == ICW'(INIT_CYC - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    prev_q   <= ab_cur;
                    i_prev_q <= fi;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.position  = pos_q;
    assign bus.dir       = dir_q;
    assign bus.step      = step_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err       = err_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter: a vector table of encoder edges and
// loads, plus hand sequences for priming, glitches, errors, wrap/saturate and priority.
module tb_quad_decoder_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       small_load;
    logic [3:0] small_val;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         w_steps  = 0;
    int         s_steps  = 0;

    always #5 clk = ~clk;

    quad_decoder_counter_if #(.CNT_W(32)) m_if ();
    quad_decoder_counter_if #(.CNT_W(4))  w_if ();
    quad_decoder_counter_if #(.CNT_W(4))  s_if ();

    quad_decoder_counter #(.CNT_W(32), .FILTER_LEN(4), .SAT_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(m_if)
    );
    quad_decoder_counter #(.CNT_W(4), .FILTER_LEN(4), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .bus(w_if)
    );
    quad_decoder_counter #(.CNT_W(4), .FILTER_LEN(4), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .bus(s_if)
    );

    // The narrow instances follow the main pins; only their load is separate.
    assign w_if.enc_a = m_if.enc_a;
    assign w_if.enc_b = m_if.enc_b;
    assign w_if.enc_i = m_if.enc_i;
    assign w_if.mode  = m_if.mode;
    assign w_if.index_clr_en = 1'b0;
    assign w_if.err_clr      = 1'b0;
    assign w_if.cnt_load     = small_load;
    assign w_if.cnt_load_val = small_val;
    assign s_if.enc_a = m_if.enc_a;
    assign s_if.enc_b = m_if.enc_b;
    assign s_if.enc_i = m_if.enc_i;
    assign s_if.mode  = m_if.mode;
    assign s_if.index_clr_en = 1'b0;
    assign s_if.err_clr      = 1'b0;
    assign s_if.cnt_load     = small_load;
    assign s_if.cnt_load_val = small_val;

    typedef struct {
        int         kind;     // 0: encoder edge, 1: position load
        logic [1:0] ab;
        logic [1:0] mode;
        int         exp_pos;
        logic       exp_dir;
        int         exp_step;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int kind, logic [1:0] ab, logic [1:0] mode,
                                int pos, logic dir, int stp);
        vec_t v;
        v.kind = kind; v.ab = ab; v.mode = mode;
        v.exp_pos = pos; v.exp_dir = dir; v.exp_step = stp;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs n clocks; optionally strobes an action for the clock edge k == act_k.
    // act: 1 err_clr, 2 main cnt_load, 3 narrow-instance cnt_load.
    task automatic run_cycles(input int n, input int act_k, input int act,
                              input int act_val, output int steps,
                              output int land, output int errs);
        steps = 0; land = 0; errs = 0;
        for (int k = 1; k <= n; k++) begin
            if (k == act_k) begin
                if (act == 1) m_if.err_clr = 1'b1;
                if (act == 2) begin
                    m_if.cnt_load     = 1'b1;
                    m_if.cnt_load_val = act_val;
                end
                if (act == 3) begin
                    small_load = 1'b1;
                    small_val  = act_val[3:0];
                end
            end
            @(posedge clk);
            #1;
            m_if.err_clr = 1'b0;
            m_if.cnt_load = 1'b0;
            small_load = 1'b0;
            if (m_if.step) begin
                steps++;
                land = k;
            end
            if (m_if.err_pulse) errs++;
            if (w_if.step) w_steps++;
            if (s_if.step) s_steps++;
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        m_if.enc_a = ab[1];
        m_if.enc_b = ab[0];
    endtask

    initial begin
        int steps, land, errs;

        rst = 1'b1;
        small_load = 1'b0;
        small_val  = '0;
        m_if.enc_a = 1'b1; m_if.enc_b = 1'b1; m_if.enc_i = 1'b0;
        m_if.mode = 2'b10; m_if.index_clr_en = 1'b0;
        m_if.cnt_load = 1'b0; m_if.cnt_load_val = '0; m_if.err_clr = 1'b0;

        // x4: three up cycles from 11, then five edges back down
        for (int c = 0; c < 3; c++) begin
            vecs.push_back(mk(0, 2'b01, 2'b10, c*4+1, 1'b1, 1));
            vecs.push_back(mk(0, 2'b00, 2'b10, c*4+2, 1'b1, 1));
            vecs.push_back(mk(0, 2'b10, 2'b10, c*4+3, 1'b1, 1));
            vecs.push_back(mk(0, 2'b11, 2'b10, c*4+4, 1'b1, 1));
        end
        vecs.push_back(mk(0, 2'b10, 2'b10, 11, 1'b0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b10, 10, 1'b0, 1));
        vecs.push_back(mk(0, 2'b01, 2'b10,  9, 1'b0, 1));
        vecs.push_back(mk(0, 2'b11, 2'b10,  8, 1'b0, 1));
        vecs.push_back(mk(0, 2'b10, 2'b10,  7, 1'b0, 1));
        // x1: three up cycles from 10, only 00->10 counts
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 1'b0, 0));
        for (int c = 0; c < 3; c++) begin
            vecs.push_back(mk(0, 2'b11, 2'b00, c, (c > 0), 0));
            vecs.push_back(mk(0, 2'b01, 2'b00, c, (c > 0), 0));
            vecs.push_back(mk(0, 2'b00, 2'b00, c, (c > 0), 0));
            vecs.push_back(mk(0, 2'b10, 2'b00, c+1, 1'b1, 1));
        end
        // x2: only A transitions count
        vecs.push_back(mk(1, 2'b10, 2'b01, 0, 1'b1, 0));
        for (int c = 0; c < 3; c++) begin
            vecs.push_back(mk(0, 2'b11, 2'b01, c*2,   1'b1, 0));
            vecs.push_back(mk(0, 2'b01, 2'b01, c*2+1, 1'b1, 1));
            vecs.push_back(mk(0, 2'b00, 2'b01, c*2+1, 1'b1, 0));
            vecs.push_back(mk(0, 2'b10, 2'b01, c*2+2, 1'b1, 1));
        end
        // reserved mode 11 behaves as x4
        vecs.push_back(mk(0, 2'b11, 2'b11, 7, 1'b1, 1));
        vecs.push_back(mk(0, 2'b10, 2'b11, 6, 1'b0, 1));

        // Reset state and priming with static pins 11
        run_cycles(3, 0, 0, 0, steps, land, errs);
        chk("rst_position", m_if.position, 0);
        chk("rst_ready", m_if.ready, 0);
        chk("rst_dir", m_if.dir, 0);
        chk("rst_err", m_if.err, 0);
        chk("rst_step", m_if.step, 0);
        rst = 1'b0;
        run_cycles(5, 0, 0, 0, steps, land, errs);
        chk("prime_not_ready_5", m_if.ready, 0);
        run_cycles(1, 0, 0, 0, steps, land, errs);
        chk("prime_ready_6", m_if.ready, 1);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("prime_no_step", steps, 0);
        chk("prime_no_err", errs, 0);
        chk("prime_position", m_if.position, 0);

        foreach (vecs[i]) begin
            m_if.mode = vecs[i].mode;
            if (vecs[i].kind == 1) begin
                run_cycles(4, 1, 2, vecs[i].exp_pos, steps, land, errs);
                chk($sformatf("vec%0d_load_pos", i), $signed(m_if.position), vecs[i].exp_pos);
            end else begin
                set_ab(vecs[i].ab);
                run_cycles(20, 0, 0, 0, steps, land, errs);
                chk($sformatf("vec%0d_pos", i), $signed(m_if.position), vecs[i].exp_pos);
                chk($sformatf("vec%0d_dir", i), m_if.dir, vecs[i].exp_dir);
                chk($sformatf("vec%0d_steps", i), steps, vecs[i].exp_step);
                chk($sformatf("vec%0d_errs", i), errs, 0);
                if (vecs[i].exp_step != 0)
                    chk($sformatf("vec%0d_latency", i), land, 7);
            end
        end

        // 3-clock glitch on A is rejected (pins at 10, x2)
        m_if.mode = 2'b01;
        m_if.enc_a = 1'b0;
        run_cycles(3, 0, 0, 0, steps, land, errs);
        m_if.enc_a = 1'b1;
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("glitch_steps", steps, 0);
        chk("glitch_pos", $signed(m_if.position), 6);

        // 10->00 down edge, then 00->11 illegal
        m_if.mode = 2'b10;
        set_ab(2'b00);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("down_pos", $signed(m_if.position), 5);
        set_ab(2'b11);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("illegal_pulses", errs, 1);
        chk("illegal_steps", steps, 0);
        chk("illegal_err", m_if.err, 1);
        chk("illegal_pos", $signed(m_if.position), 5);
        chk("illegal_dir_held", m_if.dir, 0);
        run_cycles(3, 1, 1, 0, steps, land, errs);
        chk("err_clr", m_if.err, 0);
        // err_clr on the same edge as a new illegal transition: set wins
        set_ab(2'b00);
        run_cycles(20, 7, 1, 0, steps, land, errs);
        chk("clr_vs_set_pulse", errs, 1);
        chk("clr_vs_set_err", m_if.err, 1);
        run_cycles(3, 1, 1, 0, steps, land, errs);
        chk("err_clr2", m_if.err, 0);

        // 4-bit wrap vs saturate: load 7, one up edge 00->10
        run_cycles(3, 1, 3, 7, steps, land, errs);
        chk("w_load7", $signed(w_if.position), 7);
        chk("s_load7", $signed(s_if.position), 7);
        w_steps = 0; s_steps = 0;
        set_ab(2'b10);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("main_up_pos", $signed(m_if.position), 6);
        chk("wrap_pos", $signed(w_if.position), -8);
        chk("wrap_steps", w_steps, 1);
        chk("sat_pos", $signed(s_if.position), 7);
        chk("sat_steps", s_steps, 1);
        chk("sat_dir", s_if.dir, 1);

        // Index clear beats a simultaneous step; load beats index clear
        run_cycles(3, 1, 2, 25, steps, land, errs);
        chk("load25", $signed(m_if.position), 25);
        m_if.index_clr_en = 1'b1;
        m_if.enc_i = 1'b1;
        set_ab(2'b00);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("idx_clr_pos", $signed(m_if.position), 0);
        chk("idx_clr_step", steps, 1);
        chk("idx_clr_dir", m_if.dir, 0);
        m_if.enc_i = 1'b0;
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("idx_fall_pos", $signed(m_if.position), 0);
        m_if.enc_i = 1'b1;
        set_ab(2'b10);
        run_cycles(20, 7, 2, 99, steps, land, errs);
        chk("load_vs_idx_pos", $signed(m_if.position), 99);
        chk("load_vs_idx_step", steps, 1);
        chk("load_vs_idx_dir", m_if.dir, 1);
        m_if.index_clr_en = 1'b0;

        // Reset mid-operation, then priming repeats with pins at 10
        rst = 1'b1;
        run_cycles(2, 0, 0, 0, steps, land, errs);
        chk("rst2_pos", m_if.position, 0);
        chk("rst2_ready", m_if.ready, 0);
        chk("rst2_dir", m_if.dir, 0);
        rst = 1'b0;
        run_cycles(5, 0, 0, 0, steps, land, errs);
        chk("reprime_not_ready", m_if.ready, 0);
        run_cycles(1, 0, 0, 0, steps, land, errs);
        chk("reprime_ready", m_if.ready, 1);
        run_cycles(20, 0, 0, 0, steps, land, errs);
        chk("reprime_steps", steps, 0);
        chk("reprime_errs", errs, 0);
        chk("reprime_pos", m_if.position, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
